// File: rtl/iob_eth_tx_framer_pkg.sv
`default_nettype none
// iob_eth_tx_framer_pkg: shared constants, state encodings and header byte select.
// Revision 1.0
package iob_eth_tx_framer_pkg;

    localparam int ETH_HDR_LEN = 14;
    localparam int ADDR_W      = 11;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_HDR       = 3'd1;
    localparam logic [2:0] S_PAYLOAD   = 3'd2;
    localparam logic [2:0] S_PAD       = 3'd3;
    localparam logic [2:0] S_SEND      = 3'd4;
    localparam logic [2:0] S_WAIT_DONE = 3'd5;

    // Header layout: destination MAC, source MAC, EtherType, all MSB first.
    function automatic logic [7:0] hdr_byte(
        input logic [3:0]  idx,
        input logic [47:0] dst,
        input logic [47:0] src,
        input logic [15:0] typ
    );
        logic [7:0] b;
        case (idx)
            4'd0:    b = dst[47:40];
            4'd1:    b = dst[39:32];
            4'd2:    b = dst[31:24];
            4'd3:    b = dst[23:16];
            4'd4:    b = dst[15:8];
            4'd5:    b = dst[7:0];
            4'd6:    b = src[47:40];
            4'd7:    b = src[39:32];
            4'd8:    b = src[31:24];
            4'd9:    b = src[23:16];
            4'd10:   b = src[15:8];
            4'd11:   b = src[7:0];
            4'd12:   b = typ[15:8];
            4'd13:   b = typ[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iob_eth_tx_framer.sv
`default_nettype none
// iob_eth_tx_framer: builds header + payload + zero pad in the TX buffer, then requests send.
// Revision 1.0
module iob_eth_tx_framer
    import iob_eth_tx_framer_pkg::*;
#(
    parameter logic [47:0] SRC_MAC     = 48'h0123456789AB,
    parameter int          MIN_FRAME   = 60,
    parameter int          MAX_PAYLOAD = 1500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [47:0]       dest_mac,
    input  logic [15:0]       eth_type,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              buf_wr,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [7:0]        buf_wdata,
    output logic              send,
    output logic [ADDR_W-1:0] pkt_size,
    input  logic              tx_done,
    output logic              busy,
    output logic              err
);

    localparam logic [ADDR_W-1:0] MIN_CNT  = ADDR_W'(MIN_FRAME);
    localparam logic [ADDR_W-1:0] MAX_CNT  = ADDR_W'(ETH_HDR_LEN + MAX_PAYLOAD);
    localparam logic [ADDR_W-1:0] HDR_LAST = ADDR_W'(ETH_HDR_LEN - 1);

    logic [2:0]        state_q,    state_d;
    logic [ADDR_W-1:0] cnt_q,      cnt_d;
    logic [47:0]       dmac_q,     dmac_d;
    logic [15:0]       etype_q,    etype_d;
    logic              busy_q,     busy_d;
    logic [ADDR_W-1:0] pkt_size_q, pkt_size_d;

    logic [ADDR_W-1:0] cnt_inc;
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dmac_d     = dmac_q;
        etype_d    = etype_q;
        busy_d     = busy_q;
        pkt_size_d = pkt_size_q;
        s_ready    = 1'b0;
        buf_wr     = 1'b0;
        buf_addr   = '0;
        buf_wdata  = 8'h00;
        send       = 1'b0;
        err        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dmac_d  = dest_mac;
                    etype_d = eth_type;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                buf_wr    = 1'b1;
                buf_addr  = cnt_q;
                buf_wdata = hdr_byte(cnt_q[3:0], dmac_q, SRC_MAC, etype_q);
                cnt_d     = cnt_inc;
                if (cnt_q == HDR_LAST) begin
                    state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    // One byte beyond the payload limit: drop the frame, never write it.
                    if (cnt_q == MAX_CNT) begin
                        err     = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        buf_wr    = 1'b1;
                        buf_addr  = cnt_q;
                        buf_wdata = s_data;
                        cnt_d     = cnt_inc;
                        if (s_last) begin
                            if (cnt_inc < MIN_CNT) begin
                                state_d = S_PAD;
                            end else begin
                                pkt_size_d = cnt_inc;
                                state_d    = S_SEND;
                            end
                        end
                    end
                end
            end
            S_PAD: begin
                buf_wr   = 1'b1;
                buf_addr = cnt_q;
                cnt_d    = cnt_inc;
                if (cnt_inc == MIN_CNT) begin
                    pkt_size_d = cnt_inc;
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                send    = 1'b1;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (tx_done) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // pkt_size loads on the edge into SEND so it is already valid during the send pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            dmac_q     <= '0;
            etype_q    <= '0;
            busy_q     <= 1'b0;
            pkt_size_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dmac_q     <= dmac_d;
            etype_q    <= etype_d;
            busy_q     <= busy_d;
            pkt_size_q <= pkt_size_d;
        end
    end

    assign busy     = busy_q;
    assign pkt_size = pkt_size_q;

endmodule
`default_nettype wire
